// File: rtl/elastic_pipe_pkg.sv
// Shared declarations for the elastic pipeline: default bus width, count-width
// helper and the per-stage control bundle.
package elastic_pkg;

  localparam int unsigned default_width_c = 8;

  typedef struct packed {
    logic valid;
    logic ready;
  } stage_ctrl_t;

  // Width needed to hold an occupancy of 0..depth.
  function automatic int unsigned count_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_if.sv
// Producer/consumer handshake bundle for elastic_pipe. The master side drives
// the inputs; the slave side is the pipeline itself.
interface elastic_pipe_if #(
  parameter int unsigned width_p = elastic_pkg::default_width_c,
  parameter int unsigned depth_p = 2
);
  import elastic_pkg::*;

  localparam int unsigned count_w_c = count_width(depth_p);

  // Handshake: a word moves across a boundary only in a cycle where the
  // sender's valid and the receiver's ready are both 1. valid may rise without
  // waiting for ready; once valid_o is 1 it and data_o hold until ready_i or flush.
  logic                 valid_i;
  logic                 ready_o;
  logic [width_p-1:0]   data_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [width_p-1:0]   data_o;
  logic                 flush_i;
  logic [count_w_c-1:0] count_o;

  modport master (
    output valid_i, data_i, ready_i, flush_i,
    input  ready_o, valid_o, data_o, count_o
  );

  modport slave (
    input  valid_i, data_i, ready_i, flush_i,
    output ready_o, valid_o, data_o, count_o
  );

endinterface

// File: rtl/elastic_pipe_stage.sv
// One elastic register stage: loads from upstream when empty or draining,
// drains when downstream is ready, and clears its valid bit on flush.
module elastic_stage
  import elastic_pkg::*;
#(
  parameter int unsigned width_p          = default_width_c,
  parameter bit          datapath_reset_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               up_valid,
  input  logic [width_p-1:0] up_data,
  input  logic               down_ready,
  output stage_ctrl_t        ctrl,
  output logic [width_p-1:0] data
);

  logic valid_q;
  logic load;

  assign ctrl = '{valid: valid_q, ready: ~valid_q | down_ready};
  assign load = up_valid & ctrl.ready & ~flush_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end else if (down_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Data is only ever written on a load; draining leaves the stale word behind.
  if (datapath_reset_p) begin : g_data_rst
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        data <= '0;
      end else if (load) begin
        data <= up_data;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk_i) begin
      if (load) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// depth_p-stage elastic pipeline with valid/ready backpressure, synchronous
// flush and an occupancy count.
module elastic_pipe
  import elastic_pkg::*;
#(
  parameter int unsigned width_p          = default_width_c,
  parameter int unsigned depth_p          = 2,
  parameter bit          datapath_reset_p = 1'b0
) (
  input  logic          clk_i,
  input  logic          reset_i,
  elastic_pipe_if.slave bus
);

  localparam int unsigned count_w_c = count_width(depth_p);

  if (depth_p < 1 || width_p < 1) begin : g_param_check
    $error("elastic_pipe: depth_p and width_p must both be at least 1");
  end

  logic [depth_p-1:0]   valid_vec;
  logic [count_w_c-1:0] count_sum;

  // The ready chain runs combinationally from ready_i back to stage 0.
  for (genvar k = 0; k < depth_p; k++) begin : stage_g
    stage_ctrl_t        ctrl;
    logic               up_valid;
    logic [width_p-1:0] up_data;
    logic [width_p-1:0] data;
    logic               down_ready;

    if (k == 0) begin : g_head
      assign up_valid = bus.valid_i;
      assign up_data  = bus.data_i;
    end else begin : g_link
      assign up_valid = stage_g[k-1].ctrl.valid;
      assign up_data  = stage_g[k-1].data;
    end

    if (k == depth_p - 1) begin : g_tail
      assign down_ready = bus.ready_i;
    end else begin : g_mid
      assign down_ready = stage_g[k+1].ctrl.ready;
    end

    elastic_stage #(
      .width_p         (width_p),
      .datapath_reset_p(datapath_reset_p)
    ) u_stage (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .flush_i   (bus.flush_i),
      .up_valid  (up_valid),
      .up_data   (up_data),
      .down_ready(down_ready),
      .ctrl      (ctrl),
      .data      (data)
    );

    assign valid_vec[k] = ctrl.valid;
  end

  // Occupancy is a pure function of the stage valid flops, so it only moves
  // at clock edges or on reset.
  always_comb begin
    count_sum = '0;
    for (int i = 0; i < depth_p; i++) begin
      count_sum = count_sum + count_w_c'(valid_vec[i]);
    end
  end

  assign bus.ready_o = stage_g[0].ctrl.ready & ~bus.flush_i & ~reset_i;
  assign bus.valid_o = stage_g[depth_p-1].ctrl.valid;
  assign bus.data_o  = stage_g[depth_p-1].data;
  assign bus.count_o = count_sum;

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: three depths driven by shared stimulus, a positional
// queue model per instance, an order scoreboard and hand-computed spot checks.
module tb_elastic_pipe;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       valid_i;
  logic       ready_i;
  logic       flush_i;
  logic [7:0] data_i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q [$];

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  elastic_pipe_if #(.width_p(8), .depth_p(3)) bus0 ();
  elastic_pipe_if #(.width_p(8), .depth_p(2)) bus1 ();
  elastic_pipe_if #(.width_p(8), .depth_p(4)) bus2 ();

  elastic_pipe #(.width_p(8), .depth_p(3), .datapath_reset_p(1'b1)) u_dut0 (
    .clk_i(clk), .reset_i(reset_i), .bus(bus0));
  elastic_pipe #(.width_p(8), .depth_p(2), .datapath_reset_p(1'b0)) u_dut1 (
    .clk_i(clk), .reset_i(reset_i), .bus(bus1));
  elastic_pipe #(.width_p(8), .depth_p(4), .datapath_reset_p(1'b0)) u_dut2 (
    .clk_i(clk), .reset_i(reset_i), .bus(bus2));

  assign bus0.valid_i = valid_i;  assign bus0.data_i = data_i;
  assign bus0.ready_i = ready_i;  assign bus0.flush_i = flush_i;
  assign bus1.valid_i = valid_i;  assign bus1.data_i = data_i;
  assign bus1.ready_i = ready_i;  assign bus1.flush_i = flush_i;
  assign bus2.valid_i = valid_i;  assign bus2.data_i = data_i;
  assign bus2.ready_i = ready_i;  assign bus2.flush_i = flush_i;

  logic       act_valid [3];
  logic       act_ready [3];
  logic [7:0] act_data  [3];
  logic [2:0] act_count [3];

  assign act_valid[0] = bus0.valid_o;  assign act_ready[0] = bus0.ready_o;
  assign act_data[0]  = bus0.data_o;   assign act_count[0] = {1'b0, bus0.count_o};
  assign act_valid[1] = bus1.valid_o;  assign act_ready[1] = bus1.ready_o;
  assign act_data[1]  = bus1.data_o;   assign act_count[1] = {1'b0, bus1.count_o};
  assign act_valid[2] = bus2.valid_o;  assign act_ready[2] = bus2.ready_o;
  assign act_data[2]  = bus2.data_o;   assign act_count[2] = bus2.count_o;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Each instance is a queue of words (index 0 = oldest) with a stage position.
  // Per edge every word advances one position unless blocked by the word ahead
  // of it; the oldest word leaves from the last position when ready_i is 1.
  int         m_depth [3] = '{3, 2, 4};
  int         m_n     [3] = '{0, 0, 0};
  int         m_pos   [3][8];
  logic [7:0] m_data  [3][8];

  always @(negedge clk) begin
    int   lim;
    int   np [8];
    int   k;
    int   d;
    logic dlv;
    logic exp_rdy;
    logic exp_vld;
    for (int i = 0; i < 3; i++) begin
      d = m_depth[i];
      if (reset_i) begin
        m_n[i] = 0;
        check($sformatf("rst_valid_%0d", i), 32'(act_valid[i]), 32'd0);
        check($sformatf("rst_ready_%0d", i), 32'(act_ready[i]), 32'd0);
        check($sformatf("rst_count_%0d", i), 32'(act_count[i]), 32'd0);
      end else begin
        lim = ready_i ? d : d - 1;
        for (int j = 0; j < m_n[i]; j++) begin
          np[j] = (m_pos[i][j] + 1 < lim) ? m_pos[i][j] + 1 : lim;
          lim   = np[j] - 1;
        end
        if (m_n[i] == 0) exp_rdy = !flush_i;
        else             exp_rdy = !flush_i && (np[m_n[i]-1] > 0);
        exp_vld = (m_n[i] > 0) && (m_pos[i][0] == d - 1);
        check($sformatf("valid_o_%0d", i), 32'(act_valid[i]), 32'(exp_vld));
        if (exp_vld) check($sformatf("data_o_%0d", i), 32'(act_data[i]), 32'(m_data[i][0]));
        check($sformatf("ready_o_%0d", i), 32'(act_ready[i]), 32'(exp_rdy));
        check($sformatf("count_o_%0d", i), 32'(act_count[i]), 32'(m_n[i]));
        dlv = (m_n[i] > 0) && (np[0] == d);
        if (flush_i) begin
          m_n[i] = 0;
        end else begin
          k = 0;
          for (int j = 0; j < m_n[i]; j++) begin
            if (!(j == 0 && dlv)) begin
              m_data[i][k] = m_data[i][j];
              m_pos[i][k]  = np[j];
              k++;
            end
          end
          if (valid_i && exp_rdy) begin
            m_data[i][k] = data_i;
            m_pos[i][k]  = 0;
            k++;
          end
          m_n[i] = k;
        end
      end
    end
    // order scoreboard on the depth-3 instance
    if (reset_i) begin
      exp_q.delete();
    end else begin
      if (act_valid[0] && ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_extra: got %0h, expected no word", act_data[0]);
        end else begin
          check("sb_order", 32'(act_data[0]), 32'(exp_q.pop_front()));
        end
      end
      if (flush_i) exp_q.delete();
      else if (valid_i && act_ready[0]) exp_q.push_back(data_i);
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f);
    @(posedge clk);
    #2;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // ---------------- directed + random ----------------
  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    flush_i = 1'b0;
    data_i  = 8'h00;
    #9;
    check("init_valid0", 32'(act_valid[0]), 32'd0);
    check("init_count0", 32'(act_count[0]), 32'd0);
    check("init_ready0", 32'(act_ready[0]), 32'd0);
    check("init_data0",  32'(act_data[0]),  32'd0);
    repeat (2) @(posedge clk);
    #2 reset_i = 1'b0;
    idle(2);

    // streaming, depth 3: word n visible 3 cycles after its handshake
    for (int k = 0; k < 13; k++) begin
      cyc(k < 10, 8'(k + 1), 1'b1, 1'b0);
      check($sformatf("stream_valid_%0d", k), 32'(act_valid[0]), 32'(k >= 3));
      if (k >= 3) check($sformatf("stream_data_%0d", k), 32'(act_data[0]), 32'(k - 2));
    end

    // backpressure, depth 2
    idle(6);
    cyc(1'b1, 8'hA1, 1'b0, 1'b0); check("bp_ready_a1", 32'(act_ready[1]), 32'd1);
    cyc(1'b1, 8'hA2, 1'b0, 1'b0); check("bp_ready_a2", 32'(act_ready[1]), 32'd1);
    cyc(1'b1, 8'hA3, 1'b0, 1'b0); check("bp_ready_full", 32'(act_ready[1]), 32'd0);
    check("bp_count_full", 32'(act_count[1]), 32'd2);
    cyc(1'b1, 8'hA3, 1'b0, 1'b0); check("bp_hold_data", 32'(act_data[1]), 32'hA1);
    cyc(1'b1, 8'hA3, 1'b1, 1'b0); check("bp_release_ready", 32'(act_ready[1]), 32'd1);
    check("bp_out_a1", 32'(act_data[1]), 32'hA1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0); check("bp_out_a2", 32'(act_data[1]), 32'hA2);
    cyc(1'b0, 8'h00, 1'b1, 1'b0); check("bp_out_a3", 32'(act_data[1]), 32'hA3);
    check("bp_out_a3_valid", 32'(act_valid[1]), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0); check("bp_empty", 32'(act_count[1]), 32'd0);

    // full pass-through, depth 2
    idle(6);
    cyc(1'b1, 8'hB1, 1'b0, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0, 1'b0);
    cyc(1'b1, 8'hB3, 1'b0, 1'b0); check("pt_count_full", 32'(act_count[1]), 32'd2);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 8'(8'hB3 + k), 1'b1, 1'b0);
      check($sformatf("pt_ready_%0d", k), 32'(act_ready[1]), 32'd1);
      check($sformatf("pt_count_%0d", k), 32'(act_count[1]), 32'd2);
      check($sformatf("pt_data_%0d", k),  32'(act_data[1]),  32'(8'hB1 + k));
    end

    // flush, depth 4 holding three words
    idle(6);
    cyc(1'b1, 8'hC1, 1'b0, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0, 1'b0);
    cyc(1'b1, 8'hC3, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0); check("fl_count_pre", 32'(act_count[2]), 32'd3);
    cyc(1'b1, 8'hC4, 1'b0, 1'b1); check("fl_ready", 32'(act_ready[2]), 32'd0);
    check("fl_data_pre", 32'(act_data[2]), 32'hC1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0); check("fl_count_post", 32'(act_count[2]), 32'd0);
    check("fl_valid_post", 32'(act_valid[2]), 32'd0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("fl_no_capture", 32'(act_valid[2]), 32'd0);

    // asynchronous reset with two words in flight, depth 3
    idle(6);
    cyc(1'b1, 8'hD1, 1'b0, 1'b0);
    cyc(1'b1, 8'hD2, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("ar_valid_pre", 32'(act_valid[0]), 32'd1);
    check("ar_data_pre",  32'(act_data[0]),  32'hD1);
    check("ar_count_pre", 32'(act_count[0]), 32'd2);
    @(negedge clk);
    #2 reset_i = 1'b1;
    #1;
    check("ar_valid", 32'(act_valid[0]), 32'd0);
    check("ar_count", 32'(act_count[0]), 32'd0);
    check("ar_ready", 32'(act_ready[0]), 32'd0);
    check("ar_data",  32'(act_data[0]),  32'd0);
    @(negedge clk);
    #2 reset_i = 1'b0;

    // random traffic with occasional flush
    for (int n = 0; n < 10000; n++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
    end
    idle(8);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
